// File: rtl/mac_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_vec_pkg
//  Description : Shared types and helpers for the vector MAC engine: the
//                engine state encoding, beat-count width and the lane
//                accumulator clamp limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_vec_pkg;

  // Engine states, explicitly two bits wide.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Widest accumulator the limit helpers can describe.
  localparam int c_LIMIT_W = 128;

  // Counter width able to hold the value max_len itself.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // All-ones value of width w (unsigned clamp).
  function automatic logic [c_LIMIT_W-1:0] umax_limit(input int w);
    logic [c_LIMIT_W-1:0] ones;
    ones = '1;
    return ~(ones << w);
  endfunction

  // Largest positive two's-complement value of width w.
  function automatic logic [c_LIMIT_W-1:0] smax_limit(input int w);
    return umax_limit(w - 1);
  endfunction

  // Most negative two's-complement value of width w.
  function automatic logic [c_LIMIT_W-1:0] smin_limit(input int w);
    logic [c_LIMIT_W-1:0] one;
    one = c_LIMIT_W'(1);
    return one << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lane
//  Description : One multiply-accumulate lane. Stage 1 registers the operand
//                product, stage 2 adds the extended product into the
//                accumulator and records overflow.
//                Build option MAC_VEC_SAT_EN: clamp the accumulator on
//                overflow instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lane
  import mac_vec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_prod_signed,
  input  logic                  i_acc_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_ovf
);

  localparam int c_PROD_W = 2 * DATA_WIDTH;
  localparam int c_MSB    = ACC_WIDTH - 1;

`ifdef MAC_VEC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] c_UMAX = ACC_WIDTH'(umax_limit(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] c_SMAX = ACC_WIDTH'(smax_limit(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] c_SMIN = ACC_WIDTH'(smin_limit(ACC_WIDTH));
`endif

  logic [c_PROD_W-1:0]  w_a_ext;
  logic [c_PROD_W-1:0]  w_b_ext;
  logic [c_PROD_W-1:0]  w_prod;
  logic [c_PROD_W-1:0]  r_prod;
  logic                 r_pvalid;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum_wide;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_next;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  // Widen operands to product width so one multiplier serves both modes;
  // the low 2*DW bits of the widened product are exact in either mode.
  always_comb begin
    if (i_prod_signed) begin
      w_a_ext = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
      w_b_ext = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
    end else begin
      w_a_ext = {{DATA_WIDTH{1'b0}}, i_a};
      w_b_ext = {{DATA_WIDTH{1'b0}}, i_b};
    end
    w_prod = w_a_ext * w_b_ext;
  end

  // Stage 1: capture the product of each accepted beat.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_prod   <= '0;
      r_pvalid <= 1'b0;
    end else begin
      r_pvalid <= i_load;
      if (i_load) begin
        r_prod <= w_prod;
      end
    end
  end

  // Product extension to accumulator width (none needed when widths match).
  generate
    if (ACC_WIDTH > c_PROD_W) begin : g_ext
      assign w_ext = i_acc_signed
                   ? {{(ACC_WIDTH - c_PROD_W){r_prod[c_PROD_W-1]}}, r_prod}
                   : {{(ACC_WIDTH - c_PROD_W){1'b0}}, r_prod};
    end else begin : g_no_ext
      assign w_ext = r_prod;
    end
  endgenerate

  // Stage 2 adder with overflow detection and optional clamping.
  always_comb begin
    w_sum_wide = {1'b0, r_acc} + {1'b0, w_ext};
    w_sum      = w_sum_wide[ACC_WIDTH-1:0];
    if (i_acc_signed) begin
      w_ovf = (r_acc[c_MSB] == w_ext[c_MSB]) && (w_sum[c_MSB] != r_acc[c_MSB]);
    end else begin
      w_ovf = w_sum_wide[ACC_WIDTH];
    end
    w_next = w_sum;
`ifdef MAC_VEC_SAT_EN
    // Signed overflow only happens when both addends share a sign, so the
    // accumulator sign picks the rail.
    if (w_ovf) begin
      if (!i_acc_signed) begin
        w_next = c_UMAX;
      end else if (r_acc[c_MSB]) begin
        w_next = c_SMIN;
      end else begin
        w_next = c_SMAX;
      end
    end
`endif
  end

  // Stage 2: accumulate and keep the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_pvalid) begin
      r_acc <= w_next;
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mac_vec_accum.sv
`default_nettype none
// ============================================================================
//  Module      : mac_vec_accum
//  Description : Multi-lane pipelined multiply-accumulate engine. Accumulates
//                a[i]*b[i] per lane over a framed vector of beats and emits
//                one result word per lane with a beat count and overflow flag.
//                Build option MAC_VEC_SAT_EN: lanes saturate on overflow
//                (default build wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_vec_accum
  import mac_vec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
  parameter int MAX_LEN    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic                              signed_mode,
  input  logic [LANES*DATA_WIDTH-1:0]       a_vec,
  input  logic [LANES*DATA_WIDTH-1:0]       b_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*ACC_WIDTH-1:0]        out_data,
  output logic [cnt_width(MAX_LEN)-1:0]     out_count,
  output logic                              out_ovf
);

  localparam int c_CNT_W = cnt_width(MAX_LEN);

  state_e             r_state;
  state_e             w_state_next;
  logic [c_CNT_W-1:0] r_count;
  logic               r_signed;
  logic               w_accept;
  logic               w_out_fire;
  logic               w_forced_last;
  logic               w_last;
  logic               w_prod_signed;
  logic               w_lane_clear;
  logic [LANES-1:0]   w_lane_ovf;

  assign w_accept      = in_valid & in_ready;
  assign w_out_fire    = out_valid & out_ready;
  // The MAX_LEN-th beat closes the vector even without in_last.
  assign w_forced_last = (r_count == c_CNT_W'(MAX_LEN - 1));
  assign w_last        = in_last | w_forced_last;
  // The first beat's product uses the live mode; later beats the latched one.
  assign w_prod_signed = (r_state == IDLE) ? signed_mode : r_signed;
  assign w_lane_clear  = clr | w_out_fire;

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_last ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register, beat counter and signed-mode latch.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_out_fire) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + c_CNT_W'(1);
      end
      if (w_accept && (r_state == IDLE)) begin
        r_signed <= signed_mode;
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [ACC_WIDTH-1:0] w_acc;

      mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_lane_clear),
        .i_load        (w_accept),
        .i_prod_signed (w_prod_signed),
        .i_acc_signed  (r_signed),
        .i_a           (a_vec[g*DATA_WIDTH +: DATA_WIDTH]),
        .i_b           (b_vec[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_acc         (w_acc),
        .o_ovf         (w_lane_ovf[g])
      );

      assign out_data[g*ACC_WIDTH +: ACC_WIDTH] = w_acc;
    end
  endgenerate

  assign out_count = r_count;
  assign out_ovf   = |w_lane_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_vec_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_vec_accum
//  Description : Directed self-checking bench for mac_vec_accum. Instance 1
//                uses default parameters; instance 2 is a single lane with a
//                16-bit accumulator and MAX_LEN=4 for framing and overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_vec_accum;

  logic        clk = 1'b0;
  logic        rst, clr, signed_mode, in_last;
  logic [31:0] a_vec, b_vec;
  logic        v1, v2, or1, or2;

  logic        r1, ov1, f1;
  logic [95:0] d1;
  logic [8:0]  c1;
  logic        r2, ov2, f2;
  logic [15:0] d2;
  logic [2:0]  c2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_vec_accum u_dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(v1), .in_ready(r1), .in_last(in_last), .signed_mode(signed_mode),
    .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(ov1), .out_ready(or1), .out_data(d1), .out_count(c1), .out_ovf(f1)
  );

  mac_vec_accum #(
    .DATA_WIDTH(8), .LANES(1), .ACC_WIDTH(16), .MAX_LEN(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(v2), .in_ready(r2), .in_last(in_last), .signed_mode(signed_mode),
    .a_vec(a_vec[7:0]), .b_vec(b_vec[7:0]),
    .out_valid(ov2), .out_ready(or2), .out_data(d2), .out_count(c2), .out_ovf(f2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the selected instance and hold it until accepted.
  task automatic beat(input int sel, input logic [31:0] a, input logic [31:0] b, input logic last);
    int g;
    g       = 0;
    a_vec   = a;
    b_vec   = b;
    in_last = last;
    if (sel == 1) v1 = 1'b1; else v2 = 1'b1;
    while (((sel == 1) ? !r1 : !r2) && g < 50) begin
      tick();
      g++;
    end
    chk("beat_ready_wait", (g < 50), 1'b1);
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  // Wait for out_valid on the selected instance; returns cycles waited.
  task automatic wait_res(input int sel, output int cycles);
    int g;
    g = 0;
    while (((sel == 1) ? !ov1 : !ov2) && g < 50) begin
      tick();
      g++;
    end
    chk("result_wait", (g < 50), 1'b1);
    cycles = g;
  endtask

  task automatic take(input int sel);
    if (sel == 1) or1 = 1'b1; else or2 = 1'b1;
    tick();
    or1 = 1'b0;
    or2 = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] exp_wrap_u, exp_wrap_s;

    rst = 1'b1; clr = 1'b0; signed_mode = 1'b0; in_last = 1'b0;
    a_vec = '0; b_vec = '0; v1 = 1'b0; v2 = 1'b0; or1 = 1'b0; or2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  r1,  1'b1);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_data",      d1,  96'h0);
    chk("rst_count",     c1,  9'd0);
    chk("rst_ovf",       f1,  1'b0);
    chk("rst_in_ready2", r2,  1'b1);

    // 1: unsigned 3-beat vector, one-cycle latency after the last beat
    beat(1, 32'h04030201, 32'h05050505, 1'b0);
    beat(1, 32'h04030201, 32'h05050505, 1'b0);
    beat(1, 32'h04030201, 32'h05050505, 1'b1);
    chk("t1_flush_not_ready", r1, 1'b0);
    wait_res(1, lat);
    chk("t1_latency", lat, 1);
    chk("t1_data",  d1, {24'd60, 24'd45, 24'd30, 24'd15});
    chk("t1_count", c1, 9'd3);
    chk("t1_ovf",   f1, 1'b0);
    take(1);
    chk("t1_ready_after", r1,  1'b1);
    chk("t1_valid_after", ov1, 1'b0);
    chk("t1_cleared",     d1,  96'h0);
    chk("t1_count_clr",   c1,  9'd0);

    // 2: signed single beat; mode change after the first beat is ignored
    signed_mode = 1'b1;
    beat(1, 32'hFDFDFDFD, 32'h07070707, 1'b1);
    signed_mode = 1'b0;
    wait_res(1, lat);
    chk("t2_signed_data", d1, {4{24'hFFFFEB}});
    chk("t2_count",       c1, 9'd1);
    chk("t2_ovf",         f1, 1'b0);
    take(1);
    beat(1, 32'hFDFDFDFD, 32'h07070707, 1'b1);
    wait_res(1, lat);
    chk("t2_unsigned_data", d1, {4{24'h0006EB}});

    // 3: backpressure with a pending input beat that must not be consumed
    a_vec = 32'hFFFFFFFF; b_vec = 32'hFFFFFFFF; in_last = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_data",  d1,  {4{24'h0006EB}});
      chk("t3_hold_ready", r1,  1'b0);
      chk("t3_hold_valid", ov1, 1'b1);
    end
    v1 = 1'b0;
    take(1);
    chk("t3_release_ready", r1,  1'b1);
    chk("t3_release_valid", ov1, 1'b0);
    chk("t3_release_count", c1,  9'd0);

    // 4: MAX_LEN=4 forces the fourth beat to close the vector
    for (int i = 0; i < 4; i++) beat(2, 32'h1, 32'h1, 1'b0);
    chk("t4_forced_last_ready", r2, 1'b0);
    wait_res(2, lat);
    chk("t4_sum1",   d2, 16'd4);
    chk("t4_count1", c2, 3'd4);
    chk("t4_ovf1",   f2, 1'b0);
    take(2);
    beat(2, 32'h1, 32'h1, 1'b0);
    beat(2, 32'h1, 32'h1, 1'b0);
    beat(2, 32'h1, 32'h1, 1'b1);
    wait_res(2, lat);
    chk("t4_sum2",   d2, 16'd3);
    chk("t4_count2", c2, 3'd3);
    take(2);

    // 5: 16-bit accumulator overflow, unsigned and signed
`ifdef MAC_VEC_SAT_EN
    exp_wrap_u = 16'hFFFF;
    exp_wrap_s = 16'h7FFF;
`else
    exp_wrap_u = 16'd64514;
    exp_wrap_s = 16'h8000;
`endif
    beat(2, 32'hFF, 32'hFF, 1'b0);
    beat(2, 32'hFF, 32'hFF, 1'b1);
    wait_res(2, lat);
    chk("t5_u_ovf", f2, 1'b1);
    chk("t5_u_sum", d2, exp_wrap_u);
    take(2);
    chk("t5_ovf_cleared", f2, 1'b0);
    signed_mode = 1'b1;
    beat(2, 32'h80, 32'h80, 1'b0);
    beat(2, 32'h80, 32'h80, 1'b1);
    signed_mode = 1'b0;
    wait_res(2, lat);
    chk("t5_s_ovf", f2, 1'b1);
    chk("t5_s_sum", d2, exp_wrap_s);
    take(2);

    // 6: rst mid-vector, then clr while holding a result
    beat(1, 32'h01010101, 32'h01010101, 1'b0);
    beat(1, 32'h01010101, 32'h01010101, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ready", r1,  1'b1);
    chk("t6_rst_valid", ov1, 1'b0);
    chk("t6_rst_count", c1,  9'd0);
    tick();
    chk("t6_rst_data",  d1,  96'h0);
    beat(1, 32'h09090909, 32'h09090909, 1'b1);
    wait_res(1, lat);
    chk("t6_pre_clr_data", d1, {4{24'd81}});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr_ready", r1,  1'b1);
    chk("t6_clr_valid", ov1, 1'b0);
    chk("t6_clr_data",  d1,  96'h0);
    chk("t6_clr_count", c1,  9'd0);
    chk("t6_clr_ovf",   f1,  1'b0);
    beat(1, 32'h02020202, 32'h03030303, 1'b1);
    wait_res(1, lat);
    chk("t6_new_data",  d1, {4{24'd6}});
    chk("t6_new_count", c1, 9'd1);
    take(1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
